pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Sits directly downstream of the PLL: consumes the PLL output clock and its asynchronous `locked` flag, and produces a clean, sequenced active-low system reset for the 6502 core and peripherals.
- Synchronises `locked`, requires it to stay stable before releasing reset, and holds reset for a programmable number of cycles.
- Detects loss of lock at runtime and re-enters reset; counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the `locked` synchroniser (legal 2..4).
- STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before leaving STABILIZE (legal ≥1).
- HOLD_CYCLES, 16, cycles `sys_reset_n` stays low after stabilisation (legal ≥1).
- LOSS_W, 4, width of the lock-loss event counter.
- CLKEN_DIV, 30, period in cycles of the `cpu_clken` pulse (optional feature only; legal ≥2).

Ports:
- clock_in  input  1  system clock (PLL output clock); all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset (external button, already synchronised by its source).
- locked  input  1  PLL lock flag, asynchronous to `clock_in`.
- sys_reset_n  output  1  sequenced active-low reset to the rest of the design.
- ready  output  1  high while in RUN.
- state_o  output  2  current state encoding, for debug/LED.
- loss_count  output  LOSS_W  saturating count of lock losses seen while in RUN.
- cpu_clken  output  1  one-cycle clock-enable pulse (driven 0 when CLK_ENABLE_EN is undefined).

Behaviour:
- Reset (`reset_n` = 0, sampled at the edge):
  - state = WAIT_LOCK, synchroniser cleared to 0, all counters = 0.
  - `sys_reset_n` = 0, `ready` = 0, `loss_count` = 0, `cpu_clken` = 0.
  - `reset_n` overrides every other input, including in the middle of any state.
- Synchroniser: `lock_s` is the SYNC_STAGES-deep registered copy of `locked`. A rising `locked` therefore reaches `lock_s` SYNC_STAGES cycles later. Only `lock_s` is used by the FSM.
- State encoding: WAIT_LOCK = 0, STABILIZE = 1, HOLD = 2, RUN = 3.
- WAIT_LOCK:
  - `sys_reset_n` = 0, counter cleared.
  - `lock_s` = 1 → STABILIZE.
- STABILIZE:
  - Counter increments each cycle while `lock_s` = 1.
  - `lock_s` = 0 → WAIT_LOCK, counter cleared; this is not counted as a loss.
  - Counter reaches STABLE_CYCLES−1 with `lock_s` = 1 → HOLD, counter cleared.
- HOLD:
  - `sys_reset_n` stays 0 for exactly HOLD_CYCLES cycles, then → RUN.
  - `lock_s` = 0 → WAIT_LOCK; not counted as a loss.
- RUN:
  - `sys_reset_n` = 1, `ready` = 1.
  - `lock_s` = 0 → WAIT_LOCK, and `loss_count` increments by 1, saturating at 2^LOSS_W−1 (no wrap).
- Output timing: `sys_reset_n` and `ready` are registered, and go low on the same clock edge that leaves RUN.
  - From `locked` rising at the input to `sys_reset_n` rising: SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES cycles, plus at most 1 cycle for the asynchronous sampling point.
- Lock glitch: a `lock_s` pulse of 1 cycle in WAIT_LOCK enters STABILIZE and then returns to WAIT_LOCK. `sys_reset_n` never deasserts on a glitch shorter than STABLE_CYCLES + HOLD_CYCLES.
- Counter widths are sized as clog2 of max(STABLE_CYCLES, HOLD_CYCLES) + 1. Counters never wrap within a state.

Optional Feature:
- Macro: CLK_ENABLE_EN.
- Defined:
  - A divider counter runs only in RUN.
  - `cpu_clken` = 1 for one cycle every CLKEN_DIV cycles. The first pulse comes CLKEN_DIV cycles after the edge on which `sys_reset_n` rose.
  - The divider is cleared, and `cpu_clken` forced to 0, in every other state and under reset.
- Undefined: no divider logic is built; `cpu_clken` is tied to 0.

Test Plan:
- Basic bring-up (defaults, SYNC_STAGES=2, STABLE_CYCLES=1024, HOLD_CYCLES=16): hold `reset_n`=0 for 5 cycles, release with `locked`=0 → `sys_reset_n`=0, `state_o`=0. Raise `locked` → `sys_reset_n` rises 2+1+1024+16 cycles later (±1), `ready`=1, `state_o`=3.
- Glitch rejection (STABLE_CYCLES=8, HOLD_CYCLES=4): in WAIT_LOCK, pulse `locked` high for 5 cycles → state goes 0→1→0, `sys_reset_n` stays 0, `loss_count`=0.
- Runtime loss: in RUN, drop `locked` for 3 cycles → `sys_reset_n`=0 exactly 2 cycles after the drop plus 1 register cycle, `loss_count`=1. Restore `locked` → full resequence and `ready`=1 again.
- Saturation (LOSS_W=2): cause 5 losses in RUN → `loss_count` reads 1, 2, 3, 3, 3.
- Reset mid-operation: assert `reset_n`=0 during HOLD and again during RUN → next edge `state_o`=0, `sys_reset_n`=0, `loss_count`=0. The loss counter does not increment because of this reset.
- CLK_ENABLE_EN defined, CLKEN_DIV=30: in RUN, `cpu_clken` pulses for 1 cycle every 30 cycles, the first 30 cycles after `sys_reset_n` rises. Pulses stop immediately on lock loss. Macro undefined → `cpu_clken` is constantly 0.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: turns the PLL output clock and its asynchronous lock flag
// into a sequenced active-low system reset for the 6502 core and peripherals.
// The lock flag is synchronised, must stay high for STABLE_CYCLES, then the
// reset is held for a further HOLD_CYCLES before the design is released.
// Loss of lock while running re-enters reset and is counted (saturating).
// Optional feature: define CLK_ENABLE_EN to build a CPU clock-enable divider
// that pulses cpu_clken once every CLKEN_DIV cycles while in RUN.
module pll_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_W        = 4,
    parameter int CLKEN_DIV     = 30
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              locked,
    output logic              sys_reset_n,
    output logic              ready,
    output logic [1:0]        state_o,
    output logic [LOSS_W-1:0] loss_count,
    output logic              cpu_clken
);

    localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABILIZE = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam bit PARAMS_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                               (STABLE_CYCLES >= 1) && (HOLD_CYCLES >= 1) &&
                               (LOSS_W >= 1) && (CLKEN_DIV >= 2);

    // Refuse to elaborate with parameter values the sequencer cannot honour.
    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("pll_reset_seq: illegal parameter value");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LOSS_W-1:0]      loss_q, loss_d;
    logic                   sys_reset_n_q, sys_reset_n_d;
    logic                   ready_q, ready_d;

    // Shift the asynchronous lock flag through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked};
        lock_s = sync_q[SYNC_STAGES-1];
    end

    // Sequencing FSM: wait for lock, demand it stays stable, hold, then run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Count lock losses seen only while running, stopping at the maximum.
    always_comb begin
        loss_d = loss_q;
        if ((state_q == RUN) && !lock_s && (loss_q != LOSS_MAX)) begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    // Outputs follow the next state so they change on the same edge as it.
    always_comb begin
        sys_reset_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
    end

    // Core registers; the external reset overrides everything.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            sync_q        <= '0;
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            loss_q        <= '0;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            loss_q        <= loss_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
        end
    end

`ifdef CLK_ENABLE_EN
    localparam int             DIV_W    = $clog2(CLKEN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKEN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             clken_q, clken_d;

    // Divider runs only while staying in RUN, so the first pulse lands a full
    // period after reset is released and pulses stop on the edge leaving RUN.
    always_comb begin
        div_d   = '0;
        clken_d = 1'b0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                clken_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Divider registers.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            div_q   <= '0;
            clken_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            clken_q <= clken_d;
        end
    end

    assign cpu_clken = clken_q;
`else
    assign cpu_clken = 1'b0;
`endif

    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign state_o     = state_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq. Drives two instances from the same lock and
// reset stimulus: one with default parameters, one small (STABLE=8, HOLD=4,
// LOSS_W=2). A run-length model predicts every output each cycle; directed
// checks pin latencies and counter values with hand-computed numbers.
// Honours CLK_ENABLE_EN the same way as the design.
module tb_pll_reset_seq;

    localparam int SYNC      = 2;
    localparam int BIG_S     = 1024;
    localparam int BIG_H     = 16;
    localparam int SMALL_S   = 8;
    localparam int SMALL_H   = 4;
    localparam int DIV       = 30;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       locked;

    logic       big_sysn, big_ready, big_clken;
    logic [1:0] big_state;
    logic [3:0] big_loss;

    logic       small_sysn, small_ready, small_clken;
    logic [1:0] small_state;
    logic [1:0] small_loss;

    int compared   = 0;
    int mismatched = 0;

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(BIG_S), .HOLD_CYCLES(BIG_H),
        .LOSS_W(4), .CLKEN_DIV(DIV)
    ) dut_big (
        .clock_in(clock_in), .reset_n(reset_n), .locked(locked),
        .sys_reset_n(big_sysn), .ready(big_ready), .state_o(big_state),
        .loss_count(big_loss), .cpu_clken(big_clken)
    );

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(SMALL_S), .HOLD_CYCLES(SMALL_H),
        .LOSS_W(2), .CLKEN_DIV(DIV)
    ) dut_small (
        .clock_in(clock_in), .reset_n(reset_n), .locked(locked),
        .sys_reset_n(small_sysn), .ready(small_ready), .state_o(small_state),
        .loss_count(small_loss), .cpu_clken(small_clken)
    );

    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge clock_in);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input int cycles);
        reset_n = r;
        locked  = l;
        repeat (cycles) waitCycle();
    endtask

    // Model: the state follows from how many consecutive edges the FSM has
    // seen a synchronised lock. 0 -> WAIT, 1..S -> STABILIZE,
    // S+1..S+H -> HOLD, beyond -> RUN.
    initial begin
        int   runLen [2];
        int   lossM  [2];
        logic [3:0] hist [2];
        int   stabP  [2];
        int   holdP  [2];
        int   lossMax[2];
        logic sr, sl, seen;
        bit   wasRun;
        int   expState, expSysn, expClk, n;
        int   actState, actSysn, actReady, actLoss, actClk;
        stabP   = '{BIG_S, SMALL_S};
        holdP   = '{BIG_H, SMALL_H};
        lossMax = '{15, 3};
        runLen  = '{0, 0};
        lossM   = '{0, 0};
        hist    = '{4'd0, 4'd0};
        forever begin
            @(posedge clock_in);
            sr = reset_n;
            sl = locked;
            @(negedge clock_in);
            for (int d = 0; d < 2; d++) begin
                if (!sr) begin
                    runLen[d] = 0;
                    lossM[d]  = 0;
                    hist[d]   = 4'd0;
                end else begin
                    seen   = hist[d][SYNC-1];
                    wasRun = runLen[d] > stabP[d] + holdP[d];
                    runLen[d] = seen ? runLen[d] + 1 : 0;
                    if (wasRun && !seen && lossM[d] < lossMax[d]) lossM[d]++;
                    hist[d] = {hist[d][2:0], sl};
                end
                if (runLen[d] == 0)                        expState = 0;
                else if (runLen[d] <= stabP[d])            expState = 1;
                else if (runLen[d] <= stabP[d] + holdP[d]) expState = 2;
                else                                       expState = 3;
                expSysn = (expState == 3) ? 1 : 0;
`ifdef CLK_ENABLE_EN
                n = runLen[d] - stabP[d] - holdP[d] - 1;
                expClk = (expState == 3 && n > 0 && (n % DIV) == 0) ? 1 : 0;
`else
                n = 0;
                expClk = 0;
`endif
                if (d == 0) begin
                    actState = big_state;  actSysn = big_sysn;  actReady = big_ready;
                    actLoss  = big_loss;   actClk  = big_clken;
                end else begin
                    actState = small_state; actSysn = small_sysn; actReady = small_ready;
                    actLoss  = small_loss;  actClk  = small_clken;
                end
                checkOutput($sformatf("model dut%0d state_o", d), actState, expState);
                checkOutput($sformatf("model dut%0d sys_reset_n", d), actSysn, expSysn);
                checkOutput($sformatf("model dut%0d ready", d), actReady, expSysn);
                checkOutput($sformatf("model dut%0d loss_count", d), actLoss, lossM[d]);
                checkOutput($sformatf("model dut%0d cpu_clken", d), actClk, expClk);
            end
        end
    end

    // Directed scenario with hand-computed expectations.
    initial begin
        int n, bigN, smallN, firstPulse, pulses, firstLow, maxState;
        bit sysSeenHigh;
        int expLoss[4];
        expLoss = '{2, 3, 3, 3};

        // Reset for 5 cycles with the PLL unlocked.
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("reset big state", big_state, 0);
        checkOutput("reset big sysn", big_sysn, 0);
        checkOutput("reset big ready", big_ready, 0);
        checkOutput("reset big loss", big_loss, 0);
        checkOutput("reset big clken", big_clken, 0);
        checkOutput("reset small state", small_state, 0);
        checkOutput("reset small sysn", small_sysn, 0);

        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("unlocked big state", big_state, 0);
        checkOutput("unlocked small sysn", small_sysn, 0);

        // Lock glitch of 5 cycles: shorter than STABLE on both instances.
        maxState = 0;
        sysSeenHigh = 0;
        applyStimulus(1'b1, 1'b1, 0);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) locked = 1'b0;
            waitCycle();
            if (small_state > maxState) maxState = small_state;
            if (small_sysn || big_sysn) sysSeenHigh = 1;
        end
        checkOutput("glitch max state", maxState, 1);
        checkOutput("glitch sysn seen", sysSeenHigh, 0);
        checkOutput("glitch small state end", small_state, 0);
        checkOutput("glitch small loss", small_loss, 0);
        checkOutput("glitch big state end", big_state, 0);

        // Bring-up: latency 2+1+S+H edges after locked changes.
        locked = 1'b1;
        n = 0; bigN = -1; smallN = -1;
        while (bigN < 0 && n < 2000) begin
            waitCycle();
            n++;
            if (small_sysn && smallN < 0) smallN = n;
            if (big_sysn) bigN = n;
        end
        checkOutput("bring-up big latency", bigN, 1043);
        checkOutput("bring-up small latency", smallN, 15);
        checkOutput("bring-up big ready", big_ready, 1);
        checkOutput("bring-up big state", big_state, 3);

        // Clock enable: first pulse 30 cycles after release, then every 30.
        firstPulse = -1;
        pulses = 0;
        for (int k = 1; k <= 65; k++) begin
            waitCycle();
            if (big_clken) begin
                pulses++;
                if (firstPulse < 0) firstPulse = k;
            end
        end
`ifdef CLK_ENABLE_EN
        checkOutput("clken first pulse", firstPulse, 30);
        checkOutput("clken pulse count", pulses, 2);
`else
        checkOutput("clken first pulse", firstPulse, -1);
        checkOutput("clken pulse count", pulses, 0);
`endif

        // Runtime loss: locked low for 3 cycles; reset asserts on the 3rd edge.
        locked = 1'b0;
        firstLow = -1;
        for (int i = 1; i <= 3; i++) begin
            waitCycle();
            if (!big_sysn && firstLow < 0) firstLow = i;
        end
        checkOutput("loss big sysn latency", firstLow, 3);
        checkOutput("loss big ready", big_ready, 0);
        checkOutput("loss big count", big_loss, 1);
        checkOutput("loss small count", small_loss, 1);
        locked = 1'b1;
        n = 0;
        while (!big_ready && n < 2000) begin
            waitCycle();
            n++;
        end
        checkOutput("relock big latency", n, 1043);
        checkOutput("relock big ready", big_ready, 1);
        checkOutput("relock big loss", big_loss, 1);

        // Saturation on the 2-bit counter: losses 2..5 read 2,3,3,3.
        for (int j = 0; j < 4; j++) begin
            locked = 1'b0;
            repeat (3) waitCycle();
            checkOutput($sformatf("saturate loss #%0d", j + 2), small_loss, expLoss[j]);
            locked = 1'b1;
            n = 0;
            while (!small_ready && n < 50) begin
                waitCycle();
                n++;
            end
            checkOutput($sformatf("saturate relock #%0d", j + 2), small_ready, 1);
        end
        checkOutput("saturate big loss", big_loss, 2);

        // Reset during HOLD of the small instance.
        locked = 1'b0;
        repeat (3) waitCycle();
        locked = 1'b1;
        n = 0;
        while (small_state != 2 && n < 50) begin
            waitCycle();
            n++;
        end
        checkOutput("reach hold", small_state, 2);
        reset_n = 1'b0;
        waitCycle();
        checkOutput("hold reset small state", small_state, 0);
        checkOutput("hold reset small sysn", small_sysn, 0);
        checkOutput("hold reset small loss", small_loss, 0);
        checkOutput("hold reset big loss", big_loss, 0);
        checkOutput("hold reset big state", big_state, 0);

        // Reset during RUN of both instances; not counted as a loss.
        reset_n = 1'b1;
        n = 0;
        while (!big_ready && n < 2000) begin
            waitCycle();
            n++;
        end
        checkOutput("run before reset", big_ready, 1);
        reset_n = 1'b0;
        waitCycle();
        checkOutput("run reset big state", big_state, 0);
        checkOutput("run reset big sysn", big_sysn, 0);
        checkOutput("run reset big loss", big_loss, 0);
        checkOutput("run reset small state", small_state, 0);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("after reset big loss", big_loss, 0);
        checkOutput("after reset small loss", small_loss, 0);
        checkOutput("after reset small state", small_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
